// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front-end.
package fetch_pkg;

   localparam int                ADDR_W     = 19;
   localparam int                INSTR_W    = 19;
   localparam logic [ADDR_W-1:0] RESET_PC   = 19'h100;
   localparam logic [ADDR_W-1:0] PC_STEP    = 19'h4;
   localparam int                FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; the head comes straight from storage flops, so a push
// is visible one cycle later. Flush empties it and has priority over push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    push_i,
   input  fetch_entry_t            push_dat_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    head_vld_o,
   output fetch_entry_t            head_dat_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (count_q != CNT_W'(DEPTH));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign count_o    = count_q;
   assign head_vld_o = (count_q != '0);
   assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem read at a time, gated by FIFO credit; returned words
// reach decode one cycle after rvalid. A redirect flushes the FIFO and discards any in-flight read.
module instr_fetch_unit
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o,
   input  logic               instr_ready_i,
   output logic               misalign_err_o
);

   localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              discard_q, discard_d;
   logic              misalign_q, misalign_d;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_push, fifo_pop, head_vld;
   fetch_entry_t      push_dat, head_dat;

   assign fifo_push = (state_q == WAIT) && imem_rvalid_i && !discard_q && !redirect_i;
   assign fifo_pop  = head_vld && instr_ready_i && !redirect_i;
   assign push_dat  = '{instr: imem_rdata_i, pc: req_pc_q};

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_i     (fifo_push),
      .push_dat_i (push_dat),
      .pop_i      (fifo_pop),
      .flush_i    (redirect_i),
      .count_o    (fifo_count),
      .head_vld_o (head_vld),
      .head_dat_o (head_dat)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      fetch_ptr_d = fetch_ptr_q;
      req_pc_d    = req_pc_q;
      discard_d   = discard_q;
      misalign_d  = misalign_q;
      case (state_q)
         IDLE: begin
            if (redirect_i || (fifo_count < DEPTH_C)) state_d = REQ;
         end
         REQ: begin
            if (imem_gnt_i) begin
               state_d     = WAIT;
               req_pc_d    = fetch_ptr_q;
               fetch_ptr_d = fetch_ptr_q + PC_STEP;
               discard_d   = redirect_i;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               discard_d = 1'b0;
               // Credit is judged after this push; a same-cycle pop is picked up from IDLE.
               if (redirect_i || ((fifo_count + CNT_W'(fifo_push)) < DEPTH_C)) state_d = REQ;
               else                                                            state_d = IDLE;
            end else if (redirect_i) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect_i) begin
         fetch_ptr_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
         if (|redirect_pc_i[1:0]) misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_ptr_q <= RESET_PC;
         req_pc_q    <= '0;
         discard_q   <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         fetch_ptr_q <= fetch_ptr_d;
         req_pc_q    <= req_pc_d;
         discard_q   <= discard_d;
         misalign_q  <= misalign_d;
      end
   end

   always_comb begin
      imem_req_o = (state_q == REQ);
   end

   assign imem_addr_o    = fetch_ptr_q;
   assign instr_valid_o  = head_vld;
   assign instr_o        = head_dat.instr;
   assign instr_pc_o     = head_dat.pc;
   assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        redirect_i;
   logic [18:0] redirect_pc_i;
   logic        imem_req_o;
   logic [18:0] imem_addr_o;
   logic        imem_gnt_i    = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [18:0] imem_rdata_i  = '0;
   logic        instr_valid_o;
   logic [18:0] instr_o;
   logic [18:0] instr_pc_o;
   logic        instr_ready_i;
   logic        misalign_err_o;

   bit          gnt_en;
   int          rv_lat;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;

   logic [37:0] exp_q[$];
   logic [18:0] req_log[$];
   logic [18:0] pc_log[$];
   int          pop_cyc[$];

   bit          pend_vld  = 1'b0;
   bit          pend_drop = 1'b0;
   int          pend_cnt  = 0;
   logic [18:0] pend_addr = '0;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_gnt_i     (imem_gnt_i),
      .imem_rvalid_i  (imem_rvalid_i),
      .imem_rdata_i   (imem_rdata_i),
      .instr_valid_o  (instr_valid_o),
      .instr_o        (instr_o),
      .instr_pc_o     (instr_pc_o),
      .instr_ready_i  (instr_ready_i),
      .misalign_err_o (misalign_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] mem_word(input logic [18:0] a);
      return {a[8:0], a[18:9]} ^ 19'h35A5A;
   endfunction

   function automatic logic [18:0] pc_at(input int i);
      return (pc_log.size() > i) ? pc_log[i] : 19'h7FFFF;
   endfunction

   function automatic logic [18:0] req_at(input int i);
      return (req_log.size() > i) ? req_log[i] : 19'h7FFFF;
   endfunction

   function automatic int cyc_at(input int i);
      return (pop_cyc.size() > i) ? pop_cyc[i] : 0;
   endfunction

   // Memory model + scoreboard; inputs from the stimulus process are stable here.
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         pend_vld = 1'b0;
         exp_q.delete();
         req_log.delete();
         pc_log.delete();
         pop_cyc.delete();
         imem_gnt_i    = 1'b0;
         imem_rvalid_i = 1'b0;
      end else begin
         if (exp_q.size() != 0) begin
            chk("instr_vld", instr_valid_o, 1'b1);
            chk("head", {instr_o, instr_pc_o}, exp_q[0]);
         end else begin
            chk("spurious_vld", instr_valid_o, 1'b0);
         end
         if (instr_valid_o && instr_ready_i && !redirect_i) begin
            pc_log.push_back(instr_pc_o);
            pop_cyc.push_back(cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         imem_rvalid_i = 1'b0;
         if (pend_vld) begin
            if (pend_cnt <= 1) begin
               imem_rvalid_i = 1'b1;
               imem_rdata_i  = mem_word(pend_addr);
               if (!pend_drop && !redirect_i) exp_q.push_back({mem_word(pend_addr), pend_addr});
               pend_vld = 1'b0;
            end else begin
               pend_cnt--;
               if (redirect_i) pend_drop = 1'b1;
            end
         end
         if (redirect_i) exp_q.delete();
         imem_gnt_i = gnt_en && imem_req_o;
         if (imem_gnt_i) begin
            chk("one_outstanding", {63'd0, pend_vld}, 64'd0);
            pend_vld  = 1'b1;
            pend_cnt  = rv_lat;
            pend_addr = imem_addr_o;
            pend_drop = redirect_i;
            req_log.push_back(imem_addr_o);
         end
      end
   end

   task automatic do_reset(input bit rdy, input bit gen, input int lat);
      @(posedge clk); #1;
      reset_n       = 1'b0;
      redirect_i    = 1'b0;
      instr_ready_i = rdy;
      gnt_en        = gen;
      rv_lat        = lat;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_reqs(input string tag, input int n, input int budget);
      int k = 0;
      while (req_log.size() < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk(tag, {63'd0, req_log.size() >= n}, 64'd1);
   endtask

   task automatic wait_pcs(input string tag, input int n, input int budget);
      int k = 0;
      while (pc_log.size() < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk(tag, {63'd0, pc_log.size() >= n}, 64'd1);
   endtask

   task automatic wait_req_hi(input string tag);
      int k = 0;
      while (!imem_req_o && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk(tag, imem_req_o, 1'b1);
   endtask

   task automatic pulse_redirect(input logic [18:0] pc);
      redirect_i    = 1'b1;
      redirect_pc_i = pc;
      @(posedge clk); #1;
      redirect_i    = 1'b0;
   endtask

   initial begin
      int n_req;
      int n_pc;
      reset_n       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      instr_ready_i = 1'b1;
      gnt_en        = 1'b1;
      rv_lat        = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req",  imem_req_o,     1'b0);
      chk("rst_addr", imem_addr_o,    19'h100);
      chk("rst_vld",  instr_valid_o,  1'b0);
      chk("rst_instr", instr_o,       19'h0);
      chk("rst_pc",   instr_pc_o,     19'h0);
      chk("rst_mis",  misalign_err_o, 1'b0);
      reset_n = 1'b1;

      // Streaming: gnt always, rvalid one cycle after gnt, decode always ready.
      wait_pcs("t1_pops", 3, 60);
      chk("t1_addr0", req_at(0), 19'h100);
      chk("t1_pc0", pc_at(0), 19'h100);
      chk("t1_pc1", pc_at(1), 19'h104);
      chk("t1_pc2", pc_at(2), 19'h108);
      chk("t1_rate01", cyc_at(1) - cyc_at(0), 2);
      chk("t1_rate12", cyc_at(2) - cyc_at(1), 2);

      // Decode stalled: credit limits fetch to four words.
      do_reset(1'b0, 1'b1, 1);
      repeat (30) @(posedge clk);
      #1;
      chk("t2_nreq", req_log.size(), 4);
      chk("t2_a0", req_at(0), 19'h100);
      chk("t2_a1", req_at(1), 19'h104);
      chk("t2_a2", req_at(2), 19'h108);
      chk("t2_a3", req_at(3), 19'h10C);
      chk("t2_req_off", imem_req_o, 1'b0);
      chk("t2_vld", instr_valid_o, 1'b1);
      instr_ready_i = 1'b1;
      wait_reqs("t2_resume", 5, 20);
      chk("t2_a4", req_at(4), 19'h110);

      // Redirect while waiting on the 0x104 read.
      do_reset(1'b1, 1'b1, 3);
      wait_reqs("t3_reqs", 2, 60);
      chk("t3_a1", req_at(1), 19'h104);
      pulse_redirect(19'h2040);
      n_req = req_log.size();
      n_pc  = pc_log.size();
      wait_reqs("t3_newreq", n_req + 1, 30);
      chk("t3_addr", req_at(n_req), 19'h2040);
      wait_pcs("t3_newpc", n_pc + 1, 30);
      chk("t3_pc", pc_at(n_pc), 19'h2040);

      // Grant stall: request held, retargeted by redirect.
      do_reset(1'b1, 1'b0, 1);
      wait_req_hi("t4_req");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t4_stall_req", imem_req_o, 1'b1);
         chk("t4_stall_addr", imem_addr_o, 19'h100);
      end
      pulse_redirect(19'h3000);
      chk("t4_retarget_req", imem_req_o, 1'b1);
      chk("t4_retarget_addr", imem_addr_o, 19'h3000);
      gnt_en = 1'b1;
      wait_reqs("t4_gnt", 1, 20);
      chk("t4_gnt_addr", req_at(0), 19'h3000);
      wait_pcs("t4_pop", 1, 20);
      chk("t4_pc", pc_at(0), 19'h3000);

      // Fetch pointer wrap at the top of the address space.
      do_reset(1'b1, 1'b1, 1);
      pulse_redirect(19'h7FFFC);
      wait_pcs("t5_pops", 2, 40);
      chk("t5_pc0", pc_at(0), 19'h7FFFC);
      chk("t5_pc1", pc_at(1), 19'h00000);
      chk("t5_a1", req_at(1), 19'h00000);
      chk("t5_mis", misalign_err_o, 1'b0);

      // Misaligned redirect: address aligned, sticky flag until reset.
      do_reset(1'b1, 1'b0, 1);
      wait_req_hi("t6_req");
      pulse_redirect(19'h2042);
      chk("t6_addr", imem_addr_o, 19'h2040);
      chk("t6_mis", misalign_err_o, 1'b1);
      pulse_redirect(19'h3000);
      chk("t6_addr2", imem_addr_o, 19'h3000);
      chk("t6_mis_hold", misalign_err_o, 1'b1);
      gnt_en = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("t6_mis_hold2", misalign_err_o, 1'b1);
      chk("t6_pc", pc_at(0), 19'h3000);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_mis", misalign_err_o, 1'b0);
      chk("t6_rst_addr", imem_addr_o, 19'h100);
      chk("t6_rst_req", imem_req_o, 1'b0);
      chk("t6_rst_vld", instr_valid_o, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
